tsf_timer_mc: RTL

TSF_TIMER_MC -- requirements
Module: tsf_timer_mc

---
 rtl/tsf_timer_mc_pkg.sv | 9 +
 rtl/tsf_cmp_chan.sv | 47 ++++
 rtl/tsf_timer_mc.sv | 78 +++++++
 3 files changed

// File: rtl/tsf_timer_mc_pkg.sv
// rtl/tsf_timer_mc_pkg.sv - shared board clock defaults for the TSF timer
package tsf_timer_mc_pkg;

  // 100 MHz board clock: one microsecond is 100 cycles, so the terminal count is 99.
  localparam int BOARD_CLK_MHZ    = 100;
  localparam int DEFAULT_TICK_TOP = BOARD_CLK_MHZ - 1;
  localparam int MAX_CMP          = 8;

endpackage

// File: rtl/tsf_cmp_chan.sv
// rtl/tsf_cmp_chan.sv - one TSF compare channel with one-shot or periodic reload
module tsf_cmp_chan #(
  parameter int TIMER_WIDTH = 64,
  parameter int ADJ_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TIMER_WIDTH-1:0] tsf,
  input  logic                   arm,
  input  logic                   disarm,
  input  logic [TIMER_WIDTH-1:0] val,
  input  logic [ADJ_WIDTH-1:0]   period_in,
  output logic                   hit,
  output logic                   armed
);

  logic [TIMER_WIDTH-1:0] target;
  logic [ADJ_WIDTH-1:0]   period;
  logic                   hit_cond;

  // >= rather than == so targets skipped by a load or adjust still fire
  assign hit_cond = armed && (tsf >= target);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit    <= 1'b0;
      armed  <= 1'b0;
      target <= '0;
      period <= '0;
    end else if (arm) begin
      target <= val;
      period <= period_in;
      armed  <= 1'b1;
      hit    <= 1'b0;
    end else if (disarm) begin
      armed <= 1'b0;
      hit   <= 1'b0;
    end else if (hit_cond) begin
      hit <= 1'b1;
      if (period == '0) armed <= 1'b0;
      else              target <= target + TIMER_WIDTH'(period);
    end else begin
      hit <= 1'b0;
    end
  end

endmodule

// File: rtl/tsf_timer_mc.sv
// rtl/tsf_timer_mc.sv - microsecond TSF counter with load, adjust and compare channels
module tsf_timer_mc
  import tsf_timer_mc_pkg::*;
#(
  parameter int TIMER_WIDTH = 64,
  parameter int NUM_CMP     = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int ADJ_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIV_WIDTH-1:0]             tick_top,
  input  logic                             tsf_load_control,
  input  logic [TIMER_WIDTH-1:0]           tsf_load_val,
  input  logic                             adj_valid,
  input  logic [ADJ_WIDTH-1:0]             adj_delta,
  input  logic [NUM_CMP-1:0]               cmp_arm,
  input  logic [NUM_CMP-1:0]               cmp_disarm,
  input  logic [NUM_CMP*TIMER_WIDTH-1:0]   cmp_val,
  input  logic [NUM_CMP*ADJ_WIDTH-1:0]     cmp_period,
  output logic [TIMER_WIDTH-1:0]           tsf_runtime_val,
  output logic                             tsf_pulse_1M,
  output logic [NUM_CMP-1:0]               cmp_hit,
  output logic [NUM_CMP-1:0]               cmp_armed
);

  logic [DIV_WIDTH-1:0]   presc;
  logic                   load_d;
  logic                   tick;
  logic                   load_evt;
  logic [TIMER_WIDTH-1:0] adj_ext;

  assign tick     = (presc >= tick_top);
  assign load_evt = ~tsf_load_control & load_d;
  assign adj_ext  = TIMER_WIDTH'($signed(adj_delta));

  // Load wins over adjust, adjust folds in any coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc           <= '0;
      load_d          <= 1'b0;
      tsf_runtime_val <= '0;
      tsf_pulse_1M    <= 1'b0;
    end else begin
      load_d <= tsf_load_control;
      if (load_evt) begin
        tsf_runtime_val <= tsf_load_val;
        presc           <= '0;
        tsf_pulse_1M    <= 1'b0;
      end else begin
        presc        <= tick ? '0 : presc + 1'b1;
        tsf_pulse_1M <= tick;
        if (adj_valid)
          tsf_runtime_val <= tsf_runtime_val + adj_ext + TIMER_WIDTH'(tick);
        else if (tick)
          tsf_runtime_val <= tsf_runtime_val + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_chan
    tsf_cmp_chan #(
      .TIMER_WIDTH (TIMER_WIDTH),
      .ADJ_WIDTH   (ADJ_WIDTH)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .tsf       (tsf_runtime_val),
      .arm       (cmp_arm[i]),
      .disarm    (cmp_disarm[i]),
      .val       (cmp_val[i*TIMER_WIDTH +: TIMER_WIDTH]),
      .period_in (cmp_period[i*ADJ_WIDTH +: ADJ_WIDTH]),
      .hit       (cmp_hit[i]),
      .armed     (cmp_armed[i])
    );
  end

endmodule
